nibble_sum_accumulator: RTL and testbench
=========================================

// Module: nibble_sum_accumulator
// PURPOSE
//   Sits directly downstream of the 4-bit ripple-carry adder and consumes its result {c3, s[3:0]}.
//   Sums COUNT_N consecutive adder results into an ACC_W-bit frame total.
//   Presents each total on a valid/ready output port, with a sticky overflow flag.
//   Upstream results are accepted on a valid/ready input handshake.
// PARAMETERS
//   ACC_W    8   accumulator / output width in bits; legal range >= 5
//   COUNT_N  4   adder results per frame; legal range >= 1
//   CNT_W    localparam = $clog2(COUNT_N+1); width of the sample counter
// PORTS
//   clk        in   1      sole clock; rising-edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      sum_in/carry_in hold a valid adder result
//   in_ready   out  1      block can accept a result this cycle
//   sum_in     in   4      adder sum s[3:0]
//   carry_in   in   1      adder carry-out c3
//   out_valid  out  1      acc_out/ovf_out hold a completed frame
//   out_ready  in   1      downstream accepts the frame
//   acc_out    out  ACC_W  frame total; registered
//   ovf_out    out  1      sticky: the frame total exceeded 2^ACC_W-1
//   busy       out  1      a frame is in progress (state != IDLE)
// BEHAVIOUR
//   Operand: each accepted sample is value = {carry_in,sum_in}, 5 bits, zero-extended to ACC_W+1.
//   Accept: an accept occurs when in_valid && in_ready.
//   Reset: while rst=1, and on the cycle after it is released:
//     - state=IDLE; acc_out=0, ovf_out=0, out_valid=0, busy=0, count=0
//     - in_ready=1
//   FSM states:
//     IDLE:  in_ready=1. On accept: acc<=value; ovf<=0; count<=1.
//            Next state is HOLD if COUNT_N==1, otherwise ACCUM.
//     ACCUM: in_ready=1. On accept: {c,acc}<=acc+value; count<=count+1; ovf<=ovf|c.
//            Moves to HOLD on the accept that makes count==COUNT_N.
//     HOLD:  in_ready=0; out_valid=1.
//            acc_out and ovf_out are stable while out_valid && !out_ready.
//            When out_ready=1: next cycle state=IDLE, out_valid=0, acc=0, ovf=0, count=0.
//   Latency: out_valid rises exactly 1 cycle after the COUNT_N-th accept.
//   Bubbles: cycles with in_valid=0 change neither acc nor count, in any state.
//   HOLD with in_valid=1: the sample is not consumed (in_ready=0).
//     - Upstream must hold it until in_ready returns.
//     - There is no same-cycle bypass from HOLD into a new frame.
//   Out-of-frame outputs: in IDLE/ACCUM, acc_out shows the running sum. It is only meaningful when out_valid=1.
//   Overflow (macro absent):
//     - acc wraps modulo 2^ACC_W
//     - ovf_out is set on the first carry out of bit ACC_W-1 and stays set for the rest of the frame
//   Reset mid-frame: the frame is discarded and all state returns to the reset values above.
//     - No partial frame is ever presented.
//   Width rule: the internal adder is ACC_W+1 bits. The MSB is the overflow carry and is never stored in acc.
// CONFIGURATION
//   NIBBLE_ACC_SAT_EN defined:
//     - on overflow, acc saturates to {ACC_W{1'b1}} and holds that value for the rest of the frame
//     - ovf_out still sets and is sticky
//   NIBBLE_ACC_SAT_EN undefined: wrap-around behaviour as above.
// TESTING
//   (defaults ACC_W=8, COUNT_N=4 unless noted)
//   T1 reset: assert rst mid-cycle, no clock edge -> immediately acc_out=0, out_valid=0, ovf_out=0, busy=0.
//      After release: in_ready=1.
//   T2 basic frame: accept 5'h03, 5'h05, 5'h10, 5'h1F back-to-back -> 1 cycle after the 4th accept:
//      out_valid=1, acc_out=8'h37, ovf_out=0.
//   T3 overflow, ACC_W=6: accept 5'h1F x4 -> acc_out=6'h3C, ovf_out=1.
//      With NIBBLE_ACC_SAT_EN: acc_out=6'h3F, ovf_out=1.
//   T4 backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 ->
//      out_valid, acc_out, ovf_out stable; in_ready=0; no sample consumed.
//      Then out_ready=1 -> next cycle out_valid=0, in_ready=1.
//   T5 bubbles: 5'h01 on in_valid pulses with 3-cycle gaps -> count advances only on accepts.
//      acc_out=8'h04 after the 4th accept.
//   T6 mid-frame reset: 2 accepts of 5'h1F, pulse rst, then 5'h01 x4 -> acc_out=8'h04, ovf_out=0.

Source files
------------

// File: rtl/nibble_sum_accumulator.sv
// Sums COUNT_N adder results {c3,s} into an ACC_W-bit frame total on a valid/ready port.
// Define NIBBLE_ACC_SAT_EN to saturate the total on overflow instead of wrapping.
module nibble_sum_accumulator #(
  parameter int ACC_W   = 8,
  parameter int COUNT_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sum_in,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(COUNT_N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT_N);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nx;
  logic [ACC_W:0]   value;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nx;
  logic             accept;

  assign value    = {{(ACC_W-4){1'b0}}, carry_in, sum_in};
  assign sum      = {1'b0, acc_out} + value;
  assign accept   = in_valid && in_ready;
  assign count_nx = count + CNT_W'(1);

  // The adder MSB is only the overflow carry; acc keeps ACC_W bits.
`ifdef NIBBLE_ACC_SAT_EN
  assign acc_nx = (ovf_out || sum[ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nx = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_out   <= '0;
      ovf_out   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      count     <= '0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_out <= value[ACC_W-1:0];
            ovf_out <= 1'b0;
            count   <= CNT_W'(1);
            busy    <= 1'b1;
            if (COUNT_N == 1) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_out <= acc_nx;
            ovf_out <= ovf_out | sum[ACC_W];
            count   <= count_nx;
            if (count_nx == LAST) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            acc_out   <= '0;
            ovf_out   <= 1'b0;
            count     <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          acc_out   <= '0;
          ovf_out   <= 1'b0;
          count     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_sum_accumulator.sv
// Bench for nibble_sum_accumulator: an 8-bit and a 6-bit instance,
// table vectors, handshake corner cases and random frames against a sum model.
module tb_nibble_sum_accumulator;

`ifdef NIBBLE_ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       v8 = 1'b0, rd8, c8 = 1'b0, ov8, ordy8 = 1'b0, ovf8, busy8;
  logic [3:0] s8 = '0;
  logic [7:0] acc8;

  logic       v6 = 1'b0, rd6, c6 = 1'b0, ov6, ordy6 = 1'b0, ovf6, busy6;
  logic [3:0] s6 = '0;
  logic [5:0] acc6;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_sum_accumulator #(.ACC_W(8), .COUNT_N(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rd8),
    .sum_in(s8), .carry_in(c8), .out_valid(ov8), .out_ready(ordy8),
    .acc_out(acc8), .ovf_out(ovf8), .busy(busy8)
  );

  nibble_sum_accumulator #(.ACC_W(6), .COUNT_N(4)) dut6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(rd6),
    .sum_in(s6), .carry_in(c6), .out_valid(ov6), .out_ready(ordy6),
    .acc_out(acc6), .ovf_out(ovf6), .busy(busy6)
  );

  typedef struct packed {
    logic            w6;
    logic [3:0][4:0] v;
    logic [7:0]      ea;
    logic            eo;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit w6, input logic [4:0] v);
    int n = 0;
    if (w6) begin
      v6 = 1'b1; s6 = v[3:0]; c6 = v[4];
    end else begin
      v8 = 1'b1; s8 = v[3:0]; c8 = v[4];
    end
    while (!(w6 ? rd6 : rd8)) begin
      tick();
      n++;
      if (n > 100) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    tick();
    v6 = 1'b0;
    v8 = 1'b0;
  endtask

  task automatic pop(input bit w6, input logic [7:0] ea, input logic eo,
                     input string nm);
    int n = 0;
    while (!(w6 ? ov6 : ov8)) begin
      tick();
      n++;
      if (n > 100) begin
        chk({nm, "_valid_timeout"}, 32'd0, 32'd1);
        break;
      end
    end
    chk({nm, "_acc"}, w6 ? {2'b00, acc6} : acc8, ea);
    chk({nm, "_ovf"}, w6 ? ovf6 : ovf8, eo);
    if (w6) ordy6 = 1'b1; else ordy8 = 1'b1;
    tick();
    ordy6 = 1'b0;
    ordy8 = 1'b0;
    chk({nm, "_valid_drop"}, w6 ? ov6 : ov8, 1'b0);
    chk({nm, "_ready_back"}, w6 ? rd6 : rd8, 1'b1);
  endtask

  function automatic vec_t mk(input logic w6, input logic [4:0] a,
                              input logic [4:0] b, input logic [4:0] c,
                              input logic [4:0] d, input logic [7:0] ea,
                              input logic eo);
    vec_t r;
    r.w6 = w6;
    r.v  = {d, c, b, a};
    r.ea = ea;
    r.eo = eo;
    return r;
  endfunction

  initial begin
    int          sum;
    logic [4:0]  rv;
    logic [7:0]  ea;
    logic        eo;
    bit          w6;
    int          aw;

    tbl[0] = mk(0, 5'h03, 5'h05, 5'h10, 5'h1F, 8'h37, 1'b0);
    tbl[1] = mk(0, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 8'h7C, 1'b0);
    tbl[2] = mk(0, 5'h00, 5'h00, 5'h00, 5'h00, 8'h00, 1'b0);
    tbl[3] = mk(1, 5'h1F, 5'h1F, 5'h1F, 5'h1F, SAT ? 8'h3F : 8'h3C, 1'b1);
    tbl[4] = mk(1, 5'h10, 5'h10, 5'h10, 5'h10, SAT ? 8'h3F : 8'h00, 1'b1);
    tbl[5] = mk(1, 5'h08, 5'h08, 5'h08, 5'h08, 8'h20, 1'b0);

    // reset state
    repeat (2) tick();
    chk("rst_acc", acc8, 8'h00);
    chk("rst_valid", ov8, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_ready", rd8, 1'b1);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", rd8, 1'b1);
    chk("post_rst_ovf", ovf8, 1'b0);

    // table vectors
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) put(tbl[i].w6, tbl[i].v[j]);
      pop(tbl[i].w6, tbl[i].ea, tbl[i].eo, $sformatf("tbl%0d", i));
    end

    // backpressure with a pending sample
    put(0, 5'h03); put(0, 5'h03); put(0, 5'h03); put(0, 5'h04);
    v8 = 1'b1; s8 = 4'h7; c8 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", ov8, 1'b1);
      chk("bp_acc", acc8, 8'h0D);
      chk("bp_ovf", ovf8, 1'b0);
      chk("bp_ready", rd8, 1'b0);
    end
    ordy8 = 1'b1;
    tick();
    ordy8 = 1'b0;
    chk("bp_rel_valid", ov8, 1'b0);
    chk("bp_rel_ready", rd8, 1'b1);
    chk("bp_rel_acc", acc8, 8'h00);
    chk("bp_rel_busy", busy8, 1'b0);
    tick();
    v8 = 1'b0;
    chk("bp_pend_busy", busy8, 1'b1);
    chk("bp_pend_acc", acc8, 8'h07);
    put(0, 5'h01); put(0, 5'h01); put(0, 5'h01);
    pop(0, 8'h0A, 1'b0, "bp_next");

    // bubbles between accepts
    for (int k = 0; k < 4; k++) begin
      put(0, 5'h01);
      if (k < 3) begin
        repeat (3) tick();
        chk("bub_valid", ov8, 1'b0);
        chk("bub_acc", acc8, 8'(k + 1));
      end
    end
    pop(0, 8'h04, 1'b0, "bubbles");

    // asynchronous reset mid-frame
    put(0, 5'h1F); put(0, 5'h1F);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc", acc8, 8'h00);
    chk("arst_valid", ov8, 1'b0);
    chk("arst_ovf", ovf8, 1'b0);
    chk("arst_busy", busy8, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_ready", rd8, 1'b1);
    for (int k = 0; k < 4; k++) put(0, 5'h01);
    pop(0, 8'h04, 1'b0, "arst_frame");

    // random frames against an arithmetic model
    for (int f = 0; f < 40; f++) begin
      w6  = f[0];
      aw  = w6 ? 6 : 8;
      sum = 0;
      for (int j = 0; j < 4; j++) begin
        rv = 5'($urandom_range(0, 31));
        sum += int'(rv);
        put(w6, rv);
        if (j < 3) repeat ($urandom_range(0, 2)) tick();
      end
      repeat ($urandom_range(0, 3)) tick();
      eo = (sum >= (1 << aw));
      ea = (eo && SAT) ? 8'((1 << aw) - 1) : 8'(sum % (1 << aw));
      pop(w6, ea, eo, $sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
